pipe_reg_chain: RTL and testbench
=================================

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning payload width in bits (legal range 1..64).
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of register stages (legal range 1..8).
REQ-003 SHALL have parameter RESET_VAL, default 0, meaning the value loaded into every stage data register on reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stage valid bits.
REQ-007 SHALL have port in_valid  input  1  upstream offers in_data.
REQ-008 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-009 SHALL have port in_ready  output  1  chain accepts in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  last stage holds valid payload.
REQ-011 SHALL have port out_data  output  WIDTH  last stage payload.
REQ-012 SHALL have port out_ready  input  1  downstream consumes out_data this cycle.
REQ-013 SHALL have port occupancy  output  $clog2(DEPTH+1)  count of stages with valid set.

Function
REQ-014 SHALL hold, per stage k (0 = input side, DEPTH-1 = output side), one valid bit v[k] and one WIDTH-bit data register d[k].
REQ-015 SHALL define advance of the last stage as adv[DEPTH-1] = out_ready or not v[DEPTH-1].
REQ-016 SHALL define advance of every other stage k as adv[k] = adv[k+1] or not v[k+1], computed combinationally (bubble collapsing).
REQ-017 SHALL drive in_ready = adv[0] or not v[0]; in_ready SHALL combinationally depend on out_ready.
REQ-018 SHALL, at a rising edge with stage k advancing, load d[k] and v[k] from stage k-1 (from in_data/in_valid for k = 0).
REQ-019 SHALL hold d[k] and v[k] unchanged when stage k does not advance.
REQ-020 SHALL count a transfer in only when in_valid and in_ready are both 1 at a rising edge, and a transfer out only when out_valid and out_ready are both 1.
REQ-021 SHALL drive out_valid = v[DEPTH-1] and out_data = d[DEPTH-1] directly from registers, with no combinational path from inputs.
REQ-022 SHALL give a latency of exactly DEPTH cycles from an accepted input to out_valid when out_ready is held 1.
REQ-023 SHALL sustain one transfer per cycle at full occupancy when out_ready = 1 and in_valid = 1.
REQ-024 SHALL never drop, duplicate or reorder payloads; order out equals order in.
REQ-025 SHALL, with out_ready = 0 and all stages valid, drive in_ready = 0 and hold all payloads.
REQ-026 SHALL, when flush = 1 at a rising edge, clear all v[k] to 0, leave d[k] unchanged, and accept no input that cycle; flush SHALL override in_valid and out_ready.
REQ-027 SHALL drive in_ready = 0 during any cycle in which flush = 1.
REQ-028 SHALL drive occupancy equal to the number of set v[k], registered or derived from registers; it SHALL range over 0..DEPTH.
REQ-029 SHALL, for DEPTH = 1, behave as a single elastic register: in_ready = out_ready or not out_valid.
REQ-030 SHALL leave data contents with v[k] = 0 unconstrained to observers; outputs SHALL qualify data only through out_valid.

Reset
REQ-031 SHALL, while reset = 1, force all v[k] = 0 and all d[k] = RESET_VAL immediately, independent of clk.
REQ-032 SHALL drive out_valid = 0, out_data = RESET_VAL, occupancy = 0 and in_ready = 1 during and after reset.
REQ-033 SHALL discard payloads in flight when reset asserts mid-operation; the first accepted input after deassertion SHALL be the first delivered output.
REQ-034 SHALL accept input at the first rising edge following reset deassertion.

Verification
REQ-035 Streaming: DEPTH=2, out_ready=1, in_data=0x11,0x22,0x33 on consecutive cycles -> out_data 0x11,0x22,0x33 on cycles 2,3,4; occupancy stays 2.
REQ-036 Backpressure: DEPTH=3, out_ready=0, push 0xA,0xB,0xC,0xD -> 0xD not accepted (in_ready=0 after 3 pushes), occupancy=3; release out_ready -> 0xA,0xB,0xC then 0xD in order.
REQ-037 Bubble collapse: DEPTH=3, push 0x5 then an idle cycle, out_ready=0 -> occupancy=1 and 0x5 reaches the last stage after 3 cycles; in_ready stays 1 until 3 are held.
REQ-038 Flush: DEPTH=2 holding 0x7,0x8, flush=1 with in_valid=1 in_data=0x9 -> next cycle out_valid=0, occupancy=0, 0x9 never emerges.
REQ-039 Async reset: DEPTH=4, RESET_VAL=0xFF, reset pulsed between clock edges with 2 payloads in flight -> out_valid=0 and out_data=0xFF immediately; post-reset push 0x1 -> 0x1 out after 4 cycles.
REQ-040 Random: 10000 cycles random in_valid/out_ready/flush at DEPTH=1..8 -> scoreboard matches order, occupancy equals the model every cycle.

Source files
------------

// File: rtl/pipe_reg_chain.sv
// Elastic register pipeline of DEPTH stages with valid/ready handshake,
// bubble collapsing, synchronous flush and asynchronous reset.
module pipe_reg_chain #(
   parameter int               WIDTH     = 32,
   parameter int               DEPTH     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              OCC_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [OCC_W-1:0] occupancy
);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [DEPTH-1:0] ld;
   logic [WIDTH-1:0] d_q [DEPTH];
   logic [WIDTH-1:0] d_d [DEPTH];
   logic [OCC_W-1:0] occ_cnt;

   // Stage k may load when any stage from k to the output is empty or the
   // output is being consumed; this is the recursive advance chain unrolled.
   for (genvar k = 0; k < DEPTH; k++) begin : g_ld
      assign ld[k] = out_ready | ~(&v_q[DEPTH-1:k]);
   end

   assign in_ready = ld[0] & ~flush;

   always_comb begin
      v_d = v_q;
      for (int k = 0; k < DEPTH; k++) begin
         d_d[k] = d_q[k];
      end
      if (flush) begin
         v_d = '0;
      end else begin
         if (ld[0]) begin
            v_d[0] = in_valid;
            d_d[0] = in_data;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (ld[k]) begin
               v_d[k] = v_q[k-1];
               d_d[k] = d_q[k-1];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            d_q[k] <= RESET_VAL;
         end
      end else begin
         v_q <= v_d;
         d_q <= d_d;
      end
   end

   always_comb begin
      occ_cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         occ_cnt = occ_cnt + OCC_W'(v_q[k]);
      end
   end

   assign occupancy = occ_cnt;
   assign out_valid = v_q[DEPTH-1];
   assign out_data  = d_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed and randomized checks of pipe_reg_chain across DEPTH = 1..8,
// WIDTH = 8; instance index k has DEPTH k+1, index 3 uses RESET_VAL 0xFF.
module tb_pipe_reg_chain;

   logic       clk;
   logic       reset;
   logic       iv_a  [8];
   logic [7:0] id_a  [8];
   logic       or_a  [8];
   logic       fl_a  [8];
   logic       ir_a  [8];
   logic       ov_a  [8];
   logic [7:0] od_a  [8];
   logic [3:0] occ_a [8];

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] sb [8][$];

   for (genvar g = 0; g < 8; g++) begin : g_dut
      localparam int OW = $clog2(g + 2);
      logic [OW-1:0] occ_w;
      pipe_reg_chain #(
         .WIDTH     (8),
         .DEPTH     (g + 1),
         .RESET_VAL ((g == 3) ? 8'hFF : 8'h00)
      ) u_dut (
         .clk       (clk),
         .reset     (reset),
         .flush     (fl_a[g]),
         .in_valid  (iv_a[g]),
         .in_data   (id_a[g]),
         .in_ready  (ir_a[g]),
         .out_valid (ov_a[g]),
         .out_data  (od_a[g]),
         .out_ready (or_a[g]),
         .occupancy (occ_w)
      );
      assign occ_a[g] = 4'(occ_w);
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int k, input logic iv, input logic [7:0] id,
                        input logic ordy, input logic fl);
      iv_a[k] = iv;
      id_a[k] = id;
      or_a[k] = ordy;
      fl_a[k] = fl;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [7:0] rv(input int k);
      return (k == 3) ? 8'hFF : 8'h00;
   endfunction

   initial begin
      logic       riv, rordy, rfl, exp_ir;
      logic [7:0] rid;

      for (int k = 0; k < 8; k++) begin
         iv_a[k] = 1'b0; id_a[k] = '0; or_a[k] = 1'b0; fl_a[k] = 1'b0;
      end
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("rst_ov%0d", k), ov_a[k], 0);
         chk($sformatf("rst_od%0d", k), od_a[k], rv(k));
         chk($sformatf("rst_occ%0d", k), occ_a[k], 0);
         chk($sformatf("rst_ir%0d", k), ir_a[k], 1);
      end
      tick();
      tick();
      reset = 1'b0;
      #1;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("post_rst_od%0d", k), od_a[k], rv(k));
         chk($sformatf("post_rst_ir%0d", k), ir_a[k], 1);
      end

      // streaming, DEPTH 2
      drive(1, 1, 8'h11, 1, 0);
      tick();
      chk("stream_first_accept", occ_a[1], 1);
      chk("stream_ov0", ov_a[1], 0);
      drive(1, 1, 8'h22, 1, 0);
      tick();
      chk("stream_ov1", ov_a[1], 1);
      chk("stream_d11", od_a[1], 8'h11);
      chk("stream_occ_a", occ_a[1], 2);
      drive(1, 1, 8'h33, 1, 0);
      tick();
      chk("stream_d22", od_a[1], 8'h22);
      chk("stream_occ_b", occ_a[1], 2);
      drive(1, 0, 8'h00, 1, 0);
      tick();
      chk("stream_d33", od_a[1], 8'h33);
      chk("stream_occ_c", occ_a[1], 1);
      tick();
      chk("stream_empty", ov_a[1], 0);

      // backpressure, DEPTH 3
      drive(2, 1, 8'h0A, 0, 0);
      chk("bp_ir_a", ir_a[2], 1);
      tick();
      drive(2, 1, 8'h0B, 0, 0);
      chk("bp_ir_b", ir_a[2], 1);
      tick();
      drive(2, 1, 8'h0C, 0, 0);
      chk("bp_ir_c", ir_a[2], 1);
      tick();
      drive(2, 1, 8'h0D, 0, 0);
      chk("bp_ir_full", ir_a[2], 0);
      chk("bp_occ_full", occ_a[2], 3);
      tick();
      chk("bp_hold_occ", occ_a[2], 3);
      chk("bp_hold_d", od_a[2], 8'h0A);
      drive(2, 1, 8'h0D, 1, 0);
      chk("bp_ir_release", ir_a[2], 1);
      tick();
      chk("bp_out_b", od_a[2], 8'h0B);
      drive(2, 0, 8'h00, 1, 0);
      tick();
      chk("bp_out_c", od_a[2], 8'h0C);
      tick();
      chk("bp_out_d", od_a[2], 8'h0D);
      chk("bp_out_d_v", ov_a[2], 1);
      tick();
      chk("bp_drained", occ_a[2], 0);

      // bubble collapse, DEPTH 3
      drive(2, 1, 8'h05, 0, 0);
      tick();
      chk("bub_occ1", occ_a[2], 1);
      drive(2, 0, 8'h00, 0, 0);
      chk("bub_ir_idle", ir_a[2], 1);
      tick();
      chk("bub_ov_early", ov_a[2], 0);
      tick();
      chk("bub_ov_arrive", ov_a[2], 1);
      chk("bub_d5", od_a[2], 8'h05);
      chk("bub_occ_still1", occ_a[2], 1);
      drive(2, 1, 8'h06, 0, 0);
      chk("bub_ir_2", ir_a[2], 1);
      tick();
      drive(2, 1, 8'h07, 0, 0);
      chk("bub_ir_3", ir_a[2], 1);
      tick();
      drive(2, 0, 8'h00, 0, 0);
      chk("bub_ir_full", ir_a[2], 0);
      chk("bub_occ3", occ_a[2], 3);
      drive(2, 0, 8'h00, 1, 0);
      tick();
      chk("bub_out6", od_a[2], 8'h06);
      tick();
      chk("bub_out7", od_a[2], 8'h07);
      tick();
      chk("bub_drained", occ_a[2], 0);

      // flush, DEPTH 2
      drive(1, 1, 8'h07, 0, 0);
      tick();
      drive(1, 1, 8'h08, 0, 0);
      tick();
      chk("fl_occ2", occ_a[1], 2);
      chk("fl_d7", od_a[1], 8'h07);
      drive(1, 1, 8'h09, 1, 1);
      chk("fl_ir0", ir_a[1], 0);
      tick();
      chk("fl_ov0", ov_a[1], 0);
      chk("fl_occ0", occ_a[1], 0);
      drive(1, 0, 8'h00, 1, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("fl_no9_%0d", i), ov_a[1], 0);
      end

      // async reset mid-flight, DEPTH 4, RESET_VAL 0xFF
      drive(3, 1, 8'h21, 1, 0);
      tick();
      drive(3, 1, 8'h22, 1, 0);
      tick();
      drive(3, 0, 8'h00, 1, 0);
      tick();
      tick();
      chk("ar_pre_ov", ov_a[3], 1);
      chk("ar_pre_d", od_a[3], 8'h21);
      chk("ar_pre_occ", occ_a[3], 2);
      #1 reset = 1'b1;
      #1;
      chk("ar_ov", ov_a[3], 0);
      chk("ar_d", od_a[3], 8'hFF);
      chk("ar_occ", occ_a[3], 0);
      #1 reset = 1'b0;
      drive(3, 1, 8'h01, 1, 0);
      chk("ar_ir", ir_a[3], 1);
      tick();
      drive(3, 0, 8'h00, 1, 0);
      tick();
      tick();
      chk("ar_lat3", ov_a[3], 0);
      tick();
      chk("ar_lat4_v", ov_a[3], 1);
      chk("ar_lat4_d", od_a[3], 8'h01);
      tick();
      chk("ar_done", occ_a[3], 0);

      // random traffic on every depth against a queue scoreboard
      reset = 1'b1;
      for (int k = 0; k < 8; k++) begin
         iv_a[k] = 1'b0; or_a[k] = 1'b0; fl_a[k] = 1'b0;
      end
      tick();
      reset = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         @(negedge clk);
         riv   = 1'($urandom_range(0, 1));
         rordy = 1'($urandom_range(0, 1));
         rfl   = ($urandom_range(0, 31) == 0);
         rid   = 8'($urandom);
         for (int k = 0; k < 8; k++) begin
            iv_a[k] = riv; id_a[k] = rid; or_a[k] = rordy; fl_a[k] = rfl;
         end
         #1;
         for (int k = 0; k < 8; k++) begin
            exp_ir = !rfl && ((sb[k].size() < k + 1) || rordy);
            chk($sformatf("rnd_occ_d%0d", k + 1), occ_a[k], 32'(sb[k].size()));
            chk($sformatf("rnd_ir_d%0d", k + 1), ir_a[k], exp_ir);
            if (ov_a[k])
               chk($sformatf("rnd_ov_nonempty_d%0d", k + 1), 32'(sb[k].size() != 0), 1);
            if (rfl) begin
               sb[k].delete();
            end else begin
               if (rordy && ov_a[k] && sb[k].size() > 0) begin
                  chk($sformatf("rnd_data_d%0d", k + 1), od_a[k], sb[k][0]);
                  void'(sb[k].pop_front());
               end
               if (riv && exp_ir)
                  sb[k].push_back(rid);
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
